// File: rtl/fpu_pkg.sv
// Shared single-precision float types and state encodings for the FMA core
// and its upstream dispatch stage.
package fpu_pkg;

   localparam int unsigned EXPBITS = 8;
   localparam int unsigned MANBITS = 23;
   localparam int unsigned FLOATW  = 1 + EXPBITS + MANBITS;

   typedef struct packed {
      logic               sign;
      logic [EXPBITS-1:0] exponent;
      logic [MANBITS-1:0] mantissa;
   } float_sp;

   typedef struct packed {
      float_sp a;
      float_sp b;
   } operand_pair_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } dispatch_state_e;

   typedef enum logic [2:0] {
      FMA_GET_A,
      FMA_GET_B,
      FMA_UNPACK,
      FMA_MULTIPLY,
      FMA_NORMALISE,
      FMA_PACK,
      FMA_PUT_Z
   } fma_state_e;

   // Zero of either sign; the FMA core cannot take these as operands.
   function automatic logic is_zero(input float_sp f);
      return {f.exponent, f.mantissa} == '0;
   endfunction

   function automatic float_sp signed_zero(input float_sp a, input float_sp b);
      float_sp z;
      z          = '0;
      z.sign     = a.sign ^ b.sign;
      return z;
   endfunction

endpackage

// File: rtl/fpu_operand_fifo.sv
// DEPTH-entry operand-pair FIFO with registered full/empty flags and a
// combinational head read.
module fpu_operand_fifo
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  operand_pair_t i_data,
   input  logic          i_pop,
   output operand_pair_t o_head_c,
   output logic          o_full,
   output logic          o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   operand_pair_t r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_count_nxt;

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         o_full   <= 1'b0;
         o_empty  <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         o_full  <= (w_count_nxt == CW'(DEPTH));
         o_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_head_c = r_mem[r_rd_ptr];

endmodule

// File: rtl/fpu_fma_dispatch.sv
// Issue stage for the single-precision FMA: buffers operand pairs, drives the
// FMA req/busy protocol, resolves zero operands locally and returns results.
module fpu_fma_dispatch
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned REQ_GAP = 6,
   parameter int unsigned TIMEOUT = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid_in,
   output logic        op_ready_out,
   input  logic [31:0] op_a_in,
   input  logic [31:0] op_b_in,
   output logic [31:0] fma_a_out,
   output logic [31:0] fma_b_out,
   output logic        fma_req_out,
   output logic        fma_src_busy_out,
   input  logic        fma_busy_in,
   input  logic [31:0] fma_answer_in,
   input  logic        fma_ready_in,
   input  logic        fma_overflow_in,
   input  logic        fma_underflow_in,
   output logic        res_valid_out,
   input  logic        res_ready_in,
   output logic [31:0] res_value_out,
   output logic        res_overflow_out,
   output logic        res_underflow_out,
   output logic        res_timeout_out
);

   localparam int unsigned GW = (REQ_GAP > 0) ? $clog2(REQ_GAP + 1) : 1;
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   dispatch_state_e r_state;
   dispatch_state_e w_state_nxt;

   float_sp       r_fma_a;
   float_sp       r_fma_b;
   logic          r_req;
   logic          r_src_busy;
   logic          r_ready_prev;
   logic [GW-1:0] r_gap;
   logic [TW-1:0] r_to;
   logic          r_res_valid;
   float_sp       r_res_value;
   logic          r_res_ovf;
   logic          r_res_unf;
   logic          r_res_to;

   float_sp       w_fma_a_nxt;
   float_sp       w_fma_b_nxt;
   logic          w_req_nxt;
   logic          w_src_busy_nxt;
   logic [GW-1:0] w_gap_nxt;
   logic [TW-1:0] w_to_nxt;
   logic [TW-1:0] w_to_inc;
   logic          w_res_valid_nxt;
   float_sp       w_res_value_nxt;
   logic          w_res_ovf_nxt;
   logic          w_res_unf_nxt;
   logic          w_res_to_nxt;

   operand_pair_t w_push_data;
   operand_pair_t w_head;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_ready_rise;
   logic          w_head_zero;

   assign w_push_data = '{a: op_a_in, b: op_b_in};

   fpu_operand_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_push   (op_valid_in),
      .i_data   (w_push_data),
      .i_pop    (w_pop),
      .o_head_c (w_head),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   assign w_ready_rise = fma_ready_in & ~r_ready_prev;
   assign w_head_zero  = is_zero(w_head.a) | is_zero(w_head.b);
   assign w_to_inc     = r_to + TW'(1);

   // Next-state and next-output logic; registered values hold unless changed.
   always_comb begin
      w_state_nxt     = r_state;
      w_pop           = 1'b0;
      w_req_nxt       = 1'b0;
      w_src_busy_nxt  = r_src_busy;
      w_fma_a_nxt     = r_fma_a;
      w_fma_b_nxt     = r_fma_b;
      w_gap_nxt       = (r_gap < GW'(REQ_GAP)) ? r_gap + GW'(1) : r_gap;
      w_to_nxt        = r_to;
      w_res_valid_nxt = r_res_valid;
      w_res_value_nxt = r_res_value;
      w_res_ovf_nxt   = r_res_ovf;
      w_res_unf_nxt   = r_res_unf;
      w_res_to_nxt    = r_res_to;

      unique case (r_state)
         IDLE: begin
            if (!w_empty) begin
               if (w_head_zero) begin
                  w_pop           = 1'b1;
                  w_state_nxt     = RESP;
                  w_res_valid_nxt = 1'b1;
                  w_res_value_nxt = signed_zero(w_head.a, w_head.b);
                  w_res_ovf_nxt   = 1'b0;
                  w_res_unf_nxt   = 1'b0;
                  w_res_to_nxt    = 1'b0;
               end else if (!fma_busy_in && (r_gap >= GW'(REQ_GAP))) begin
                  w_pop          = 1'b1;
                  w_state_nxt    = ISSUE;
                  w_fma_a_nxt    = w_head.a;
                  w_fma_b_nxt    = w_head.b;
                  w_req_nxt      = 1'b1;
                  w_src_busy_nxt = 1'b1;
               end
            end
         end

         ISSUE: begin
            w_state_nxt = WAIT;
            w_to_nxt    = '0;
            w_gap_nxt   = '0;
         end

         // A level already high on entry is not an answer; only a fresh edge is.
         WAIT: begin
            w_to_nxt = w_to_inc;
            if (w_ready_rise) begin
               w_state_nxt     = RESP;
               w_src_busy_nxt  = 1'b0;
               w_res_valid_nxt = 1'b1;
               w_res_value_nxt = fma_answer_in;
               w_res_ovf_nxt   = fma_overflow_in;
               w_res_unf_nxt   = fma_underflow_in;
               w_res_to_nxt    = 1'b0;
            end else if (w_to_inc >= TW'(TIMEOUT)) begin
               w_state_nxt     = RESP;
               w_src_busy_nxt  = 1'b0;
               w_res_valid_nxt = 1'b1;
               w_res_value_nxt = '0;
               w_res_ovf_nxt   = 1'b0;
               w_res_unf_nxt   = 1'b0;
               w_res_to_nxt    = 1'b1;
            end
         end

         RESP: begin
            if (res_ready_in) begin
               w_state_nxt     = IDLE;
               w_res_valid_nxt = 1'b0;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Gap counter preloads to REQ_GAP so the first request is not delayed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_fma_a      <= '0;
         r_fma_b      <= '0;
         r_req        <= 1'b0;
         r_src_busy   <= 1'b0;
         r_ready_prev <= 1'b0;
         r_gap        <= GW'(REQ_GAP);
         r_to         <= '0;
         r_res_valid  <= 1'b0;
         r_res_value  <= '0;
         r_res_ovf    <= 1'b0;
         r_res_unf    <= 1'b0;
         r_res_to     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fma_a      <= w_fma_a_nxt;
         r_fma_b      <= w_fma_b_nxt;
         r_req        <= w_req_nxt;
         r_src_busy   <= w_src_busy_nxt;
         r_ready_prev <= fma_ready_in;
         r_gap        <= w_gap_nxt;
         r_to         <= w_to_nxt;
         r_res_valid  <= w_res_valid_nxt;
         r_res_value  <= w_res_value_nxt;
         r_res_ovf    <= w_res_ovf_nxt;
         r_res_unf    <= w_res_unf_nxt;
         r_res_to     <= w_res_to_nxt;
      end
   end

   assign op_ready_out      = ~w_full;
   assign fma_a_out         = r_fma_a;
   assign fma_b_out         = r_fma_b;
   assign fma_req_out       = r_req;
   assign fma_src_busy_out  = r_src_busy;
   assign res_valid_out     = r_res_valid;
   assign res_value_out     = r_res_value;
   assign res_overflow_out  = r_res_ovf;
   assign res_underflow_out = r_res_unf;
   assign res_timeout_out   = r_res_to;

endmodule

// File: tb/tb_fpu_fma_dispatch.sv
// Bench for fpu_fma_dispatch: behavioural FMA responder, result scoreboard
// and a directed-then-random stimulus sequence.
module tb_fpu_fma_dispatch;

   localparam int REQ_GAP = 6;
   localparam int TIMEOUT = 16;

   logic        clk;
   logic        rst;
   logic        op_valid_in;
   logic        op_ready_out;
   logic [31:0] op_a_in;
   logic [31:0] op_b_in;
   logic [31:0] fma_a_out;
   logic [31:0] fma_b_out;
   logic        fma_req_out;
   logic        fma_src_busy_out;
   logic        fma_busy_in;
   logic [31:0] fma_answer_in;
   logic        fma_ready_in;
   logic        fma_overflow_in;
   logic        fma_underflow_in;
   logic        res_valid_out;
   logic        res_ready_in;
   logic [31:0] res_value_out;
   logic        res_overflow_out;
   logic        res_underflow_out;
   logic        res_timeout_out;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_req    = 0;
   int          last_req_cyc = 0;

   bit          stub_hang = 0;
   int          stub_lat  = 0;
   bit          rr_random = 0;
   bit          rr_level  = 0;

   logic [34:0] exp_q[$];

   fpu_fma_dispatch #(
      .DEPTH   (4),
      .REQ_GAP (REQ_GAP),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .op_valid_in       (op_valid_in),
      .op_ready_out      (op_ready_out),
      .op_a_in           (op_a_in),
      .op_b_in           (op_b_in),
      .fma_a_out         (fma_a_out),
      .fma_b_out         (fma_b_out),
      .fma_req_out       (fma_req_out),
      .fma_src_busy_out  (fma_src_busy_out),
      .fma_busy_in       (fma_busy_in),
      .fma_answer_in     (fma_answer_in),
      .fma_ready_in      (fma_ready_in),
      .fma_overflow_in   (fma_overflow_in),
      .fma_underflow_in  (fma_underflow_in),
      .res_valid_out     (res_valid_out),
      .res_ready_in      (res_ready_in),
      .res_value_out     (res_value_out),
      .res_overflow_out  (res_overflow_out),
      .res_underflow_out (res_underflow_out),
      .res_timeout_out   (res_timeout_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Answers the FMA model gives: known products for the directed pairs,
   // an arbitrary but deterministic mix of the operands otherwise.
   function automatic logic [31:0] fma_answer(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] key;
      key = {a, b};
      case (key)
         64'h3f800000_3f800000: return 32'h3f800000;
         64'h41700000_c1a00000: return 32'hc3960000;
         64'hc1d00000_41f80000: return 32'hc4498000;
         default:               return a ^ {b[15:0], b[31:16]} ^ 32'h5a5a0000;
      endcase
   endfunction

   function automatic logic [1:0] fma_flags(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] key;
      key = {a, b};
      case (key)
         64'h3f800000_3f800000,
         64'h41700000_c1a00000,
         64'hc1d00000_41f80000: return 2'b00;
         default:               return {a[30] & b[30], a[29] ^ b[28]};
      endcase
   endfunction

   // Expected {value, overflow, underflow, timeout} for one operand pair.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input bit hang);
      logic [31:0] z;
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) begin
         z = 32'd0;
         z[31] = a[31] ^ b[31];
         return {z, 3'b000};
      end
      if (hang) return {32'd0, 3'b001};
      return {fma_answer(a, b), fma_flags(a, b), 1'b0};
   endfunction

   // FMA responder: answers each req after a latency, or never when hung.
   initial begin
      logic [31:0] ca;
      logic [31:0] cb;
      int          lat;
      fma_busy_in      = 1'b0;
      fma_ready_in     = 1'b0;
      fma_answer_in    = 32'd0;
      fma_overflow_in  = 1'b0;
      fma_underflow_in = 1'b0;
      forever begin
         @(negedge clk);
         if (fma_req_out === 1'b1 && rst === 1'b0 && !stub_hang) begin
            ca = fma_a_out;
            cb = fma_b_out;
            fma_busy_in = 1'b1;
            lat = (stub_lat != 0) ? stub_lat : int'($urandom_range(1, 10));
            for (int k = 0; k < lat; k++) begin
               @(negedge clk);
               if (fma_src_busy_out === 1'b1)
                  chk("operand_stable", {fma_a_out, fma_b_out}, {ca, cb});
            end
            fma_answer_in = fma_answer(ca, cb);
            {fma_overflow_in, fma_underflow_in} = fma_flags(ca, cb);
            fma_ready_in = 1'b1;
            repeat (2) @(negedge clk);
            fma_ready_in = 1'b0;
            fma_busy_in  = 1'b0;
         end
      end
   end

   // Request protocol monitor.
   initial begin
      bit have_last;
      bit prev_req;
      have_last = 0;
      prev_req  = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            have_last = 0;
            prev_req  = 0;
         end else begin
            if (fma_req_out === 1'b1) begin
               chk("req_single_cycle", 64'(prev_req), 64'd0);
               chk("req_with_src_busy", 64'(fma_src_busy_out), 64'd1);
               if (have_last)
                  chk("req_spacing", 64'((cyc - last_req_cyc) >= REQ_GAP + 1), 64'd1);
               have_last    = 1;
               last_req_cyc = cyc;
               n_req++;
            end
            prev_req = fma_req_out;
         end
      end
   end

   initial begin
      res_ready_in = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         res_ready_in = rr_random ? 1'($urandom_range(0, 1)) : rr_level;
      end
   end

   // Result scoreboard: in-order compare on each handshake, hold while stalled.
   initial begin
      logic [34:0] prev;
      bit          prev_hold;
      prev_hold = 0;
      prev      = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            prev_hold = 0;
         end else begin
            if (prev_hold)
               chk("result_held", {res_valid_out, res_value_out, res_overflow_out,
                                   res_underflow_out, res_timeout_out}, {1'b1, prev});
            if (res_valid_out === 1'b1 && res_ready_in === 1'b1) begin
               chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0)
                  chk("result", {res_value_out, res_overflow_out, res_underflow_out,
                                 res_timeout_out}, exp_q.pop_front());
            end
            prev_hold = (res_valid_out === 1'b1) && (res_ready_in === 1'b0);
            prev = {res_value_out, res_overflow_out, res_underflow_out, res_timeout_out};
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      op_valid_in = 1'b1;
      op_a_in     = a;
      op_b_in     = b;
      @(negedge clk);
      while (op_ready_out !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("push_accepted", 64'(op_ready_out), 64'd1);
      @(posedge clk);
      #1;
      op_valid_in = 1'b0;
      exp_q.push_back(model(a, b, stub_hang));
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (res_valid_out !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(res_valid_out), 64'd1);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_res_valid"}, 64'(res_valid_out), 64'd0);
      chk({tag, "_res_fields"}, {res_value_out, res_overflow_out, res_underflow_out,
                                 res_timeout_out}, 64'd0);
      chk({tag, "_fma_ops"}, {fma_a_out, fma_b_out}, 64'd0);
      chk({tag, "_fma_ctl"}, {fma_req_out, fma_src_busy_out}, 64'd0);
      chk({tag, "_op_ready"}, 64'(op_ready_out), 64'd1);
   endtask

   initial begin
      int          nr;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      bit          seen_valid;
      bit          seen_req;

      rst         = 1'b0;
      op_valid_in = 1'b0;
      op_a_in     = 32'd0;
      op_b_in     = 32'd0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // 1.0 x 1.0 through the FMA path, exactly one request.
      rr_level = 0;
      nr = n_req;
      push(32'h3f800000, 32'h3f800000);
      wait_valid("t1_valid");
      chk("t1_value", 64'(res_value_out), 64'h3f800000);
      chk("t1_flags", {res_overflow_out, res_underflow_out, res_timeout_out}, 64'd0);
      chk("t1_req_count", 64'(n_req - nr), 64'd1);
      rr_level = 1;
      drain("t1_drain");

      // Two back-to-back pairs; spacing checked by the monitor.
      nr = n_req;
      push(32'h41700000, 32'hc1a00000);
      push(32'hc1d00000, 32'h41f80000);
      drain("t2_drain");
      chk("t2_req_count", 64'(n_req - nr), 64'd2);

      // Zero operand bypass: result one cycle after the pop, no request.
      rr_level = 0;
      nr = n_req;
      push(32'h80000000, 32'h3f800000);
      @(negedge clk);
      chk("byp_not_yet", 64'(res_valid_out), 64'd0);
      @(negedge clk);
      chk("byp_valid", 64'(res_valid_out), 64'd1);
      chk("byp_value", 64'(res_value_out), 64'h80000000);
      rr_level = 1;
      drain("byp_drain");
      chk("byp_no_req", 64'(n_req - nr), 64'd0);

      // Hung FMA: timeout result after TIMEOUT wait cycles.
      stub_hang = 1;
      rr_level  = 0;
      push(32'h3f800000, 32'h40400000);
      wait_valid("to_valid");
      chk("to_latency", 64'(cyc - last_req_cyc), 64'(TIMEOUT + 1));
      chk("to_fields", {res_value_out, res_timeout_out}, {32'd0, 1'b1});
      stub_hang = 0;
      rr_level  = 1;
      drain("to_drain");

      // Back-pressure: one in flight plus a full FIFO.
      rr_level = 0;
      for (int i = 0; i < 5; i++) begin
         a = $urandom | 32'h1;
         b = $urandom | 32'h2;
         push(a, b);
      end
      @(negedge clk);
      chk("full_ready_low", 64'(op_ready_out), 64'd0);
      repeat (20) @(negedge clk);
      chk("full_ready_held", 64'(op_ready_out), 64'd0);
      chk("full_result_waiting", 64'(res_valid_out), 64'd1);
      rr_level = 1;
      drain("full_drain");
      chk("full_ready_back", 64'(op_ready_out), 64'd1);

      // Random pairs with random result back-pressure and FMA latency.
      rr_random = 1;
      for (int i = 0; i < 24; i++) begin
         a   = $urandom;
         b   = $urandom;
         sel = int'($urandom_range(0, 3));
         if (sel == 0) a[30:0] = 31'd0;
         else if (sel == 1) b[30:0] = 31'd0;
         else begin
            a[0] = 1'b1;
            b[1] = 1'b1;
         end
         push(a, b);
      end
      rr_random = 0;
      rr_level  = 1;
      drain("rand_drain");

      // Reset while waiting on the FMA; the late answer must be ignored.
      stub_lat = 10;
      push(32'h40000000, 32'h40400000);
      sel = 0;
      @(negedge clk);
      while (fma_req_out !== 1'b1 && sel < 100) begin
         @(negedge clk);
         sel++;
      end
      chk("rst_req_seen", 64'(fma_req_out), 64'd1);
      repeat (3) @(negedge clk);
      chk("rst_in_wait", 64'(fma_src_busy_out), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("async_rst");
      repeat (2) @(negedge clk);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      seen_valid = 0;
      seen_req   = 0;
      repeat (25) begin
         @(negedge clk);
         if (res_valid_out === 1'b1) seen_valid = 1;
         if (fma_req_out === 1'b1) seen_req = 1;
      end
      chk("post_rst_no_result", 64'(seen_valid), 64'd0);
      chk("post_rst_no_req", 64'(seen_req), 64'd0);
      stub_lat = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
